// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// States, grant-side encoding and wait-counter width.
package mem_arb_pkg;

  // Arbiter states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  // Grant side encoding (also the last_grant register)
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  // Wait counter; it restarts on every grant, so 4 bits
  // cover the whole 1..15 latency range without wrapping.
  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t lat_to_cnt(input int lat);
    return cnt_t'(lat);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request picker for the memory arbiter.
// Ports: i_elig/d_elig in, last_grant in, grant_valid/grant_side out.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_elig,
  input  logic d_elig,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_side
);

  always_comb begin
    grant_valid = i_elig | d_elig;
    grant_side  = GNT_I;
    unique case (1'b1)
      // Conflict: alternate away from the last winner
      (i_elig & d_elig):  grant_side = ~last_grant;
      (d_elig & ~i_elig): grant_side = GNT_D;
      default:            grant_side = GNT_I;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between I-fetch and D ports.
// Ports: clock/reset; i_req/i_addr -> i_ack/i_rdata;
// d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata;
// mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <-;
// busy = an access is in flight.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam cnt_t LAT = lat_to_cnt(MEM_LATENCY);

  arb_state_t state;
  cnt_t       cnt;
  logic       last_grant;

  logic i_elig;
  logic d_elig;
  logic gnt_v;
  logic gnt_s;
  logic lat_hit;

  // A side being acked this cycle must not be re-granted
  // on the same, still-high request.
  assign i_elig  = i_req & ~i_ack;
  assign d_elig  = d_req & ~d_ack;
  assign lat_hit = (cnt == LAT);
  assign busy    = (state != IDLE);

  mem_arb_pick u_pick (
    .i_elig      (i_elig),
    .d_elig      (d_elig),
    .last_grant  (last_grant),
    .grant_valid (gnt_v),
    .grant_side  (gnt_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= GNT_I;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      i_ack  <= 1'b0;
      d_ack  <= 1'b0;
      mem_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_v) begin
            last_grant <= gnt_s;
            cnt        <= '0;
            mem_en     <= 1'b1;
            if (gnt_s == GNT_D) begin
              state     <= D_BUSY;
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
            end else begin
              state     <= I_BUSY;
              mem_addr  <= i_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end
          end
        end
        I_BUSY: begin
          if (lat_hit) begin
            i_rdata <= mem_rdata;
            i_ack   <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        D_BUSY: begin
          if (lat_hit) begin
            // Stores leave the load register untouched
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
            d_ack <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table,
// reset/latency sequences and randomized traffic vs a model.
module tb_mem_arbiter;

  localparam int L = 2;

  localparam logic [31:0] A40  = 32'h8C01_0004;
  localparam logic [31:0] A44  = 32'h3333_4444;
  localparam logic [31:0] A48  = 32'h7777_8888;
  localparam logic [31:0] A100 = 32'h1111_2222;
  localparam logic [31:0] A104 = 32'h5555_6666;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;

  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L)
  ) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Latency-extreme instances, fetch port only
  logic        l1_req = 1'b0;
  logic        l15_req = 1'b0;
  logic        l1_ack, l15_ack;
  logic [31:0] l1_ird, l15_ird;
  logic        l1_dack, l15_dack;
  logic [31:0] l1_drd, l15_drd;
  logic        l1_en, l15_en;
  logic        l1_we, l15_we;
  logic [31:0] l1_ma, l15_ma;
  logic [31:0] l1_mwd, l15_mwd;
  logic        l1_busy, l15_busy;

  mem_arbiter #(.MEM_LATENCY(1)) dut_l1 (
    .clock(clock), .reset(reset),
    .i_req(l1_req), .i_addr(32'h0000_0010),
    .i_ack(l1_ack), .i_rdata(l1_ird),
    .d_req(1'b0), .d_we(1'b0),
    .d_addr(32'h0), .d_wdata(32'h0),
    .d_ack(l1_dack), .d_rdata(l1_drd),
    .mem_en(l1_en), .mem_we(l1_we),
    .mem_addr(l1_ma), .mem_wdata(l1_mwd),
    .mem_rdata(32'h0000_1111), .busy(l1_busy)
  );

  mem_arbiter #(.MEM_LATENCY(15)) dut_l15 (
    .clock(clock), .reset(reset),
    .i_req(l15_req), .i_addr(32'h0000_0020),
    .i_ack(l15_ack), .i_rdata(l15_ird),
    .d_req(1'b0), .d_we(1'b0),
    .d_addr(32'h0), .d_wdata(32'h0),
    .d_ack(l15_dack), .d_rdata(l15_drd),
    .mem_en(l15_en), .mem_we(l15_we),
    .mem_addr(l15_ma), .mem_wdata(l15_mwd),
    .mem_rdata(32'h0000_F0F0), .busy(l15_busy)
  );

  // Background memory contents
  function automatic logic [31:0] seed(input logic [9:0] ix);
    case (ix)
      10'h010: return A40;
      10'h011: return A44;
      10'h012: return A48;
      10'h040: return A100;
      10'h041: return A104;
      default: return {6'h2A, ix, 6'h15, ix};
    endcase
  endfunction

  // Memory model: data valid exactly L cycles after mem_en
  logic [31:0] mem [1024];
  bit          wrv [1024];
  bit [3:0]    lat_cnt;
  logic [9:0]  pidx;

  always @(posedge clock) begin
    if (mem_en) begin
      lat_cnt <= 4'd1;
      pidx    <= mem_addr[11:2];
      if (mem_we) begin
        mem[mem_addr[11:2]] <= mem_wdata;
        wrv[mem_addr[11:2]] <= 1'b1;
      end
    end else if (lat_cnt != 4'd0 && lat_cnt != 4'hF) begin
      lat_cnt <= lat_cnt + 4'd1;
    end
  end

  assign mem_rdata = (int'(lat_cnt) == L)
    ? (wrv[pidx] ? mem[pidx] : seed(pidx))
    : 32'hBAD0_BAD0;

  // Reference storage used by the random-traffic model
  logic [31:0] refm [1024];
  bit          refv [1024];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return refv[a[11:2]] ? refm[a[11:2]] : seed(a[11:2]);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          ir;
    logic [31:0] ia;
    bit          dr;
    bit          we;
    logic [31:0] da;
    logic [31:0] wd;
    bit          en;
    logic [31:0] ea;
    bit          ew;
    bit          bz;
    bit          ik;
    bit          dk;
    logic [31:0] ird;
    logic [31:0] drd;
  } vec_t;

  vec_t tv[$];

  function automatic void v(
    bit ir, logic [31:0] ia, bit dr, bit we,
    logic [31:0] da, logic [31:0] wd,
    bit en, logic [31:0] ea, bit ew, bit bz,
    bit ik, bit dk, logic [31:0] ird, logic [31:0] drd);
    vec_t r;
    r.ir = ir; r.ia = ia; r.dr = dr; r.we = we;
    r.da = da; r.wd = wd; r.en = en; r.ea = ea;
    r.ew = ew; r.bz = bz; r.ik = ik; r.dk = dk;
    r.ird = ird; r.drd = drd;
    tv.push_back(r);
  endfunction

  bit rand_on = 1'b0;

  task automatic run_i(input int n);
    for (int k = 0; k < n; k++) begin
      bit got;
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
      i_addr = 32'($urandom_range(0, 63)) << 2;
      i_req  = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 64 && !got; w++) begin
        @(negedge clock);
        got = i_ack;
      end
      chk("rnd.i_ack_seen", {31'b0, got}, 32'd1);
      @(posedge clock);
      #1;
      i_req = 1'b0;
    end
  endtask

  task automatic run_d(input int n);
    for (int k = 0; k < n; k++) begin
      bit got;
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
      d_addr  = 32'h80 + (32'($urandom_range(0, 63)) << 2);
      d_we    = 1'($urandom_range(0, 1));
      d_wdata = $urandom;
      d_req   = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 64 && !got; w++) begin
        @(negedge clock);
        got = d_ack;
      end
      chk("rnd.d_ack_seen", {31'b0, got}, 32'd1);
      @(posedge clock);
      #1;
      d_req = 1'b0;
    end
  endtask

  // Transaction-level model: one access at a time, mem_en the
  // cycle after an idle cycle with an eligible requester, ack
  // L+1 cycles after mem_en, conflicts alternate.
  task automatic model();
    bit          m_out = 1'b0;
    bit          m_side = 1'b0;
    bit          lg = 1'b0;
    bit          p_idle = 1'b1;
    bit          p_ie = 1'b0;
    bit          p_de = 1'b0;
    int          en_c = 0;
    logic [31:0] o_addr = '0;
    logic [31:0] o_wd = '0;
    bit          o_we = 1'b0;
    logic [31:0] i_hold = '0;
    logic [31:0] d_hold = '0;
    for (int c = 0; c < 20000; c++) begin
      bit eik, edk, een, side;
      @(negedge clock);
      if (!rand_on) break;
      eik = 1'b0;
      edk = 1'b0;
      if (m_out && c == en_c + L + 1) begin
        if (m_side) edk = 1'b1;
        else        eik = 1'b1;
        m_out = 1'b0;
        if (eik) i_hold = ref_rd(o_addr);
        if (edk && !o_we) d_hold = ref_rd(o_addr);
        if (edk && o_we) begin
          refm[o_addr[11:2]] = o_wd;
          refv[o_addr[11:2]] = 1'b1;
        end
      end
      chk("rnd.i_ack", {31'b0, i_ack}, {31'b0, eik});
      chk("rnd.d_ack", {31'b0, d_ack}, {31'b0, edk});
      chk("rnd.i_rdata", i_rdata, i_hold);
      chk("rnd.d_rdata", d_rdata, d_hold);
      een = p_idle && (p_ie || p_de);
      chk("rnd.mem_en", {31'b0, mem_en}, {31'b0, een});
      if (een) begin
        side   = (p_ie && p_de) ? ~lg : p_de;
        lg     = side;
        m_out  = 1'b1;
        m_side = side;
        en_c   = c;
        o_addr = side ? d_addr : i_addr;
        o_we   = side ? d_we : 1'b0;
        o_wd   = d_wdata;
        chk("rnd.mem_addr", mem_addr, o_addr);
        chk("rnd.mem_we", {31'b0, mem_we}, {31'b0, o_we});
        if (o_we) chk("rnd.mem_wdata", mem_wdata, o_wd);
      end
      chk("rnd.busy", {31'b0, busy}, {31'b0, m_out});
      p_idle = !m_out;
      p_ie   = i_req && !eik;
      p_de   = d_req && !edk;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ne, na, en_at, ack_at;
    int c1, c15, n1, n15;
    bit dp1, dp15;

    // conflict after reset, alternation, third pair
    v(1,'h44,1,0,'h100,0, 0,0,0,0, 0,0, 0,0);
    v(1,'h44,1,0,'h100,0, 1,'h100,0,1, 0,0, 0,0);
    v(1,'h44,1,0,'h100,0, 0,0,0,1, 0,0, 0,0);
    v(1,'h44,1,0,'h100,0, 0,0,0,1, 0,0, 0,0);
    v(1,'h44,1,0,'h100,0, 0,0,0,0, 0,1, 0,A100);
    v(1,'h44,0,0,'h100,0, 1,'h44,0,1, 0,0, 0,A100);
    v(1,'h44,0,0,'h100,0, 0,0,0,1, 0,0, 0,A100);
    v(1,'h44,0,0,'h100,0, 0,0,0,1, 0,0, 0,A100);
    v(1,'h44,0,0,'h100,0, 0,0,0,0, 1,0, A44,A100);
    v(0,'h44,0,0,'h100,0, 0,0,0,0, 0,0, A44,A100);
    v(1,'h48,1,0,'h104,0, 0,0,0,0, 0,0, A44,A100);
    v(1,'h48,1,0,'h104,0, 1,'h104,0,1, 0,0, A44,A100);
    v(1,'h48,1,0,'h104,0, 0,0,0,1, 0,0, A44,A100);
    v(1,'h48,1,0,'h104,0, 0,0,0,1, 0,0, A44,A100);
    v(1,'h48,1,0,'h104,0, 0,0,0,0, 0,1, A44,A104);
    v(1,'h48,0,0,'h104,0, 1,'h48,0,1, 0,0, A44,A104);
    v(1,'h48,0,0,'h104,0, 0,0,0,1, 0,0, A44,A104);
    v(1,'h48,0,0,'h104,0, 0,0,0,1, 0,0, A44,A104);
    v(1,'h48,0,0,'h104,0, 0,0,0,0, 1,0, A48,A104);
    v(0,'h48,0,0,'h104,0, 0,0,0,0, 0,0, A48,A104);
    // single fetch, req held through ack then dropped
    v(1,'h40,0,0,'h104,0, 0,0,0,0, 0,0, A48,A104);
    v(1,'h40,0,0,'h104,0, 1,'h40,0,1, 0,0, A48,A104);
    v(1,'h40,0,0,'h104,0, 0,0,0,1, 0,0, A48,A104);
    v(1,'h40,0,0,'h104,0, 0,0,0,1, 0,0, A48,A104);
    v(1,'h40,0,0,'h104,0, 0,0,0,0, 1,0, A40,A104);
    v(0,'h40,0,0,'h104,0, 0,0,0,0, 0,0, A40,A104);
    v(0,'h40,0,0,'h104,0, 0,0,0,0, 0,0, A40,A104);
    // store, then read it back
    v(0,'h40,1,1,'h200,'hDEADBEEF, 0,0,0,0, 0,0, A40,A104);
    v(0,'h40,1,1,'h200,'hDEADBEEF, 1,'h200,1,1, 0,0, A40,A104);
    v(0,'h40,1,1,'h200,'hDEADBEEF, 0,0,0,1, 0,0, A40,A104);
    v(0,'h40,1,1,'h200,'hDEADBEEF, 0,0,0,1, 0,0, A40,A104);
    v(0,'h40,1,1,'h200,'hDEADBEEF, 0,0,0,0, 0,1, A40,A104);
    v(0,'h40,0,0,'h200,0, 0,0,0,0, 0,0, A40,A104);
    v(0,'h40,1,0,'h200,0, 0,0,0,0, 0,0, A40,A104);
    v(0,'h40,1,0,'h200,0, 1,'h200,0,1, 0,0, A40,A104);
    v(0,'h40,1,0,'h200,0, 0,0,0,1, 0,0, A40,A104);
    v(0,'h40,1,0,'h200,0, 0,0,0,1, 0,0, A40,A104);
    v(0,'h40,1,0,'h200,0, 0,0,0,0, 0,1, A40,32'hDEADBEEF);
    v(0,'h40,0,0,'h200,0, 0,0,0,0, 0,0, A40,32'hDEADBEEF);

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst.i_ack", {31'b0, i_ack}, 32'd0);
    chk("rst.d_ack", {31'b0, d_ack}, 32'd0);
    chk("rst.mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.i_rdata", i_rdata, 32'd0);
    chk("rst.d_rdata", d_rdata, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    reset = 1'b0;

    // directed vector table
    for (int n = 0; n < tv.size(); n++) begin
      @(posedge clock);
      #1;
      i_req = tv[n].ir;  i_addr = tv[n].ia;
      d_req = tv[n].dr;  d_we = tv[n].we;
      d_addr = tv[n].da; d_wdata = tv[n].wd;
      @(negedge clock);
      chk($sformatf("v%0d.mem_en", n),
          {31'b0, mem_en}, {31'b0, tv[n].en});
      chk($sformatf("v%0d.busy", n),
          {31'b0, busy}, {31'b0, tv[n].bz});
      chk($sformatf("v%0d.i_ack", n),
          {31'b0, i_ack}, {31'b0, tv[n].ik});
      chk($sformatf("v%0d.d_ack", n),
          {31'b0, d_ack}, {31'b0, tv[n].dk});
      chk($sformatf("v%0d.i_rdata", n), i_rdata, tv[n].ird);
      chk($sformatf("v%0d.d_rdata", n), d_rdata, tv[n].drd);
      if (tv[n].en) begin
        chk($sformatf("v%0d.mem_addr", n), mem_addr, tv[n].ea);
        chk($sformatf("v%0d.mem_we", n),
            {31'b0, mem_we}, {31'b0, tv[n].ew});
      end
      if (tv[n].ew)
        chk($sformatf("v%0d.mem_wdata", n), mem_wdata, tv[n].wd);
    end

    // reset in the middle of a D read
    @(posedge clock);
    #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    @(posedge clock);
    @(negedge clock);
    chk("rmid.en_before", {31'b0, mem_en}, 32'd1);
    @(posedge clock);
    #1;
    chk("rmid.busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rmid.busy", {31'b0, busy}, 32'd0);
    chk("rmid.mem_en", {31'b0, mem_en}, 32'd0);
    chk("rmid.d_ack", {31'b0, d_ack}, 32'd0);
    chk("rmid.d_rdata", d_rdata, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rmid.en_release", {31'b0, mem_en}, 32'd0);
    ne = 0; na = 0; en_at = -1; ack_at = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock);
      #1;
      if (na > 0) d_req = 1'b0;
      @(negedge clock);
      if (mem_en) begin
        ne++;
        if (en_at < 0) en_at = c;
      end
      if (d_ack) begin
        na++;
        if (ack_at < 0) ack_at = c;
      end
    end
    chk("rmid.en_cycle", en_at, 32'd1);
    chk("rmid.ack_cycle", ack_at, 32'(L + 2));
    chk("rmid.en_count", ne, 32'd1);
    chk("rmid.ack_count", na, 32'd1);
    chk("rmid.d_rdata_new", d_rdata, A100);

    // randomized traffic against the model
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    rand_on = 1'b1;
    fork
      begin
        fork
          run_i(40);
          run_d(40);
        join
        repeat (L + 4) @(posedge clock);
        rand_on = 1'b0;
      end
      model();
    join

    // latency extremes
    @(posedge clock);
    #1;
    l1_req = 1'b1;
    l15_req = 1'b1;
    c1 = -1; c15 = -1; n1 = 0; n15 = 0;
    dp1 = 1'b0; dp15 = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (c > 0) begin
        @(posedge clock);
        #1;
        if (dp1) l1_req = 1'b0;
        if (dp15) l15_req = 1'b0;
      end
      @(negedge clock);
      if (l1_ack) begin
        n1++;
        if (c1 < 0) c1 = c;
        dp1 = 1'b1;
      end
      if (l15_ack) begin
        n15++;
        if (c15 < 0) c15 = c;
        dp15 = 1'b1;
      end
    end
    chk("lat1.ack_cycle", c1, 32'd3);
    chk("lat1.ack_count", n1, 32'd1);
    chk("lat1.i_rdata", l1_ird, 32'h0000_1111);
    chk("lat1.busy_end", {31'b0, l1_busy}, 32'd0);
    chk("lat15.ack_cycle", c15, 32'd17);
    chk("lat15.ack_count", n15, 32'd1);
    chk("lat15.i_rdata", l15_ird, 32'h0000_F0F0);
    chk("lat15.busy_end", {31'b0, l15_busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port and its data (MEM-stage) port.
- Serialises requests with a small FSM and a fixed-latency wait counter.
- Returns read data with one-cycle acks. The CPU stalls the stage whose ack has not arrived yet.
- Sits between the cpu instance and the external memory, replacing the separate instruction and data memories.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- DATA_WIDTH, 32, width of all data ports.
- MEM_LATENCY, 2, cycles from the memory sampling mem_en=1 to mem_rdata being valid. Legal range is 1 to 15.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction-fetch request; held high until i_ack.
- i_addr  in  ADDR_WIDTH  fetch address; stable while i_req is high.
- i_ack  out  1  one-cycle pulse; i_rdata is valid in the same cycle.
- i_rdata  out  DATA_WIDTH  fetched word; registered, held until the next I read.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_ack  out  1  one-cycle completion pulse for reads and writes.
- d_rdata  out  DATA_WIDTH  load data; registered, updated only on read acks.
- mem_en  out  1  one-cycle access strobe to the memory.
- mem_we  out  1  write enable; meaningful only while mem_en is high.
- mem_addr  out  ADDR_WIDTH  registered; held for the whole access.
- mem_wdata  out  DATA_WIDTH  registered; held for the whole access.
- mem_rdata  in  DATA_WIDTH  valid MEM_LATENCY cycles after the mem_en cycle.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, counter=0, last_grant=I.
  - All outputs 0, including i_rdata and d_rdata.
  - An in-flight access is discarded and no ack is issued. mem_en drops in the same cycle reset asserts.
- States:
  - IDLE: no access in flight.
  - I_BUSY: instruction access in flight.
  - D_BUSY: data access in flight.
- IDLE arbitration, sampled each cycle:
  - A requester whose ack is high in the current cycle is ineligible. This blocks re-grant of a request already being acknowledged.
  - Only one side eligible: grant that side.
  - Both eligible: grant the side not equal to last_grant. The first conflict after reset therefore goes to D.
  - On grant, at the clock edge: update last_grant, register addr/we/wdata onto mem_*, set mem_en=1 for the first BUSY cycle, set counter=0. A granted I access always has mem_we=0.
- BUSY:
  - mem_en=1 in the first cycle only; mem_addr, mem_we and mem_wdata stay stable.
  - The counter increments each cycle.
  - In the cycle where counter==MEM_LATENCY, mem_rdata is valid. At the end of that cycle: capture it into the granted side's rdata (data reads only for D), pulse that side's ack for the next cycle, and go to IDLE.
- Latency: request seen in IDLE in cycle t gives mem_en in t+1 and ack in t+MEM_LATENCY+2.
- Throughput: the earliest next grant is in the ack cycle itself, for the other requester only.
- Writes: d_ack timing is identical to reads, and d_rdata is unchanged.
- A requester dropping its req mid-access is illegal. The access still completes and acks.
- The counter width is 4 bits. No wrap occurs because the counter resets on every grant.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state localparams IDLE=2'd0, I_BUSY=2'd1, D_BUSY=2'd2;
  - grant encoding GNT_I=1'b0, GNT_D=1'b1;
  - counter width constant.
- One sub-module, mem_arb_pick: a combinational two-way picker with inputs i_elig, d_elig, last_grant and outputs grant_valid and grant_side.
- The FSM, counter and registers stay in mem_arbiter.

Test Plan (MEM_LATENCY=2 unless stated):
- Single fetch: i_req=1, i_addr=0x40 at cycle 0; memory returns 0x8C010004 at cycle 3. Required: mem_en=1 and mem_addr=0x40 at cycle 1 only; i_ack=1 with i_rdata=0x8C010004 at cycle 4; busy high for cycles 1-3.
- Conflict and alternation after reset: i_req and d_req both held from cycle 0 (d_addr=0x100, d_we=0). Required: D granted first (mem_addr=0x100 at cycle 1), d_ack at 4, I granted in IDLE cycle 4 with mem_addr=i_addr at cycle 5, i_ack at 8. A third simultaneous pair is then granted to D.
- Store: d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF. Required: mem_we=1 and mem_wdata=0xDEADBEEF with mem_en at cycle 1; d_ack at 4; d_rdata keeps its previous value.
- Ack-cycle re-grant block: i_req held high through the i_ack cycle and then dropped. Required: exactly one mem_en pulse and exactly one i_ack.
- Reset mid-access: assert reset at cycle 2 of a D read. Required: busy, mem_en and d_ack go to 0 asynchronously. After release with d_req=1, a fresh access starts, mem_en is seen 1 cycle later, and only one d_ack occurs.
- MEM_LATENCY=1 and MEM_LATENCY=15 rebuilds: ack arrives exactly 3 and 17 cycles after the request respectively.
